ps2_keyboard_port: RTL
======================

// Module: ps2_keyboard_port
// PURPOSE
//  PS/2 keyboard port. Owns the open-drain clkps2/dataps2 pins of the board top level.
//  - Receives device frames and queues the bytes in a small FIFO for the chipset keyboard logic.
//  - Sends host command bytes (LEDs, reset, typematic) to the keyboard.
//  - Runs entirely in the clk_chipset (50 MHz) domain.
// PARAMETERS
//  CLK_HZ       50_000_000  clk_chipset frequency; all time constants derive from it
//  FIFO_DEPTH   8           RX byte FIFO entries (power of two, >=2)
//  FILTER_LEN   8           consecutive equal samples before a filtered line changes level
//  TIMEOUT_US   2000        max gap between device clock falling edges inside a frame
//  INHIBIT_US   100         host clock-low hold time before a TX start bit
// PORTS
//  clk_chipset    in     1  system clock, rising edge
//  reset_n        in     1  asynchronous active-low reset
//  clkps2         inout  1  PS/2 clock; driven 0 or Z only
//  dataps2        inout  1  PS/2 data; driven 0 or Z only
//  rx_data        out    8  FIFO head byte; valid while rx_valid=1
//  rx_valid       out    1  FIFO not empty
//  rx_ready       in     1  pop the head when rx_valid && rx_ready
//  rx_error       out    1  1-cycle pulse: bad parity, bad stop bit or RX timeout
//  rx_overflow    out    1  1-cycle pulse: good byte dropped because the FIFO was full
//  tx_data        in     8  byte to send; sampled on an accepted tx_start
//  tx_start       in     1  send request; accepted only when tx_busy=0
//  tx_busy        out    1  1 from the cycle after acceptance until TX completes
//  tx_done        out    1  1-cycle pulse: device ACK (data=0) seen
//  tx_err         out    1  1-cycle pulse: no ACK (data=1) or TX timeout
// BEHAVIOUR
//  Reset: both pins Z; FIFO empty; rx_valid=0; rx_data=0; all pulses 0; tx_busy=0; FSM=IDLE.
//  Reset asserted mid-frame discards the partial frame and releases the pins at once.
//  Input conditioning:
//  - Each pin passes a 2-FF synchroniser, then a FILTER_LEN glitch filter.
//  - A device "edge" is a 1->0 transition of the filtered clock. Edge-to-action latency is 2+FILTER_LEN cycles.
//  - Timeout counter: reloads on every edge and counts only in non-IDLE states.
//    Expiry at TIMEOUT_US*CLK_HZ/1e6 cycles.
//  FSM states:
//    IDLE, RX_DATA, RX_PARITY, RX_STOP, TX_WAIT, TX_INHIBIT, TX_BITS, TX_ACK, TX_RELEASE.
//  RX path:
//  - IDLE + edge with data=0 -> RX_DATA. An edge with data=1 is ignored (no start bit).
//  - RX_DATA: shift 8 bits LSB first -> RX_PARITY -> RX_STOP.
//  - At the stop edge: data=1 and odd parity over data+parity -> push the byte, then IDLE.
//    Otherwise rx_error pulses and the byte is discarded.
//  - Timeout in any RX state: rx_error pulses, return to IDLE.
//  FIFO: first-word-fall-through.
//  - A push is visible on rx_data/rx_valid in the next cycle.
//  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
//  - Push while full with no pop: byte dropped, rx_overflow pulses, contents unchanged.
//  - Pop while empty: ignored.
//  TX path:
//  - tx_start with tx_busy=0: tx_data latched, parity computed.
//    From IDLE go to TX_INHIBIT; from an RX state go to TX_WAIT.
//  - TX_WAIT: the RX frame completes (or times out) with the normal RX side effects, then TX_INHIBIT.
//  - tx_start while tx_busy=1 is ignored.
//  - TX_INHIBIT: clkps2 driven 0 for INHIBIT_US. Then dataps2 driven 0 and clkps2 released -> TX_BITS.
//  - TX_BITS: on each device edge, present the next bit on dataps2 (0 = drive 0, 1 = Z):
//    8 data bits LSB first, then parity, then release for the stop bit.
//    The 10th edge -> TX_ACK.
//  - TX_ACK: at the next edge sample data; 0 -> tx_done, 1 -> tx_err. Then TX_RELEASE.
//  - TX_RELEASE: wait until both filtered lines are high -> IDLE; tx_busy drops that cycle.
//  - Timeout in any TX state after TX_INHIBIT: release both pins, tx_err pulses, return to IDLE.
//  - Bytes received during TX are not expected. Edges in TX states are never treated as RX.
// TESTING
//  1 Device sends 0x1C (parity 0, stop 1) at 12.5 kHz -> rx_valid=1, rx_data=0x1C, no rx_error.
//  2 Device sends 0x1C with parity=1 -> rx_error pulses once; rx_valid stays 0.
//  3 Nine frames 0x01..0x09 with rx_ready=0 -> FIFO holds 0x01..0x08, one rx_overflow pulse;
//    popping returns 0x01..0x08 in order.
//  4 Device sends start bit + 3 bits, then stops clocking -> after 2 ms rx_error pulses, FSM back to IDLE;
//    a following 0xAA frame is received correctly.
//  5 tx_start with tx_data=0xED -> clkps2 low 100 us; model sees bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
//    model ACKs -> tx_done pulse, tx_busy falls, model receives 0xED.
//  6 tx_start issued mid-RX of 0xFA -> 0xFA queued first, then TX runs;
//    a model with no ACK -> tx_err pulse, both pins Z.

Source files
------------

// File: rtl/ps2_keyboard_port.sv
// rtl/ps2_keyboard_port.sv - PS/2 keyboard port: filtered device-to-host RX into a FWFT byte FIFO, host-to-device TX.
module ps2_keyboard_port #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000,
  parameter int INHIBIT_US = 100
) (
  input  logic       clk_chipset,
  input  logic       reset_n,
  inout  wire        clkps2,
  inout  wire        dataps2,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_error,
  output logic       rx_overflow,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int TO_CYC  = int'(64'(TIMEOUT_US) * 64'(CLK_HZ) / 64'd1_000_000);
  localparam int INH_CYC = int'(64'(INHIBIT_US) * 64'(CLK_HZ) / 64'd1_000_000);
  localparam int TO_W    = $clog2(TO_CYC + 1);
  localparam int INH_W   = $clog2(INH_CYC + 1);
  localparam int FW      = $clog2(FILTER_LEN + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [3:0] {
    IDLE, RX_DATA, RX_PARITY, RX_STOP, TX_WAIT, TX_INHIBIT, TX_BITS, TX_ACK, TX_RELEASE
  } state_t;

  // Index 0 is the clock line, index 1 the data line; both idle high.
  logic [1:0]    pin_s1_q, pin_s2_q, filt_q, filt_prev_q;
  logic [FW-1:0] flt_cnt_q [2];

  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) begin
      pin_s1_q    <= 2'b11;
      pin_s2_q    <= 2'b11;
      filt_q      <= 2'b11;
      filt_prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
    end else begin
      pin_s1_q    <= {dataps2, clkps2};
      pin_s2_q    <= pin_s1_q;
      filt_prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (pin_s2_q[i] == filt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i]    <= pin_s2_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic dev_edge, data_f;
  assign dev_edge = filt_prev_q[0] & ~filt_q[0];
  assign data_f   = filt_q[1];

  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_par_q, rx_par_d;
  logic [9:0]       tx_sh_q, tx_sh_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q;
  logic             clk_low_q, clk_low_d, data_low_q, data_low_d;
  logic             rx_error_q, rx_err_d, tx_done_q, tx_done_d, tx_err_q, tx_err_d;
  logic             rx_overflow_q;
  logic             timeout, tx_accept, push, rx_end;

  assign timeout   = (to_cnt_q == TO_W'(TO_CYC - 1));
  assign tx_busy   = state_q inside {TX_WAIT, TX_INHIBIT, TX_BITS, TX_ACK, TX_RELEASE};
  assign tx_accept = tx_start && !tx_busy;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    tx_sh_d    = tx_sh_q;
    inh_cnt_d  = '0;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    rx_err_d   = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    push       = 1'b0;
    rx_end     = 1'b0;
    if (tx_accept) tx_sh_d = {1'b1, ~^tx_data, tx_data};
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (tx_accept) state_d = TX_INHIBIT;
        else if (dev_edge && !data_f) state_d = RX_DATA;
      end
      RX_DATA, RX_PARITY, RX_STOP, TX_WAIT: begin
        // bit_cnt_q tracks frame position so TX_WAIT can finish the frame it interrupted.
        if (timeout) begin
          rx_err_d = 1'b1;
          rx_end   = 1'b1;
        end else if (dev_edge) begin
          if (bit_cnt_q < 4'd8) begin
            rx_sh_d   = {data_f, rx_sh_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (bit_cnt_q == 4'd8) begin
            rx_par_d  = data_f;
            bit_cnt_d = 4'd9;
          end else begin
            rx_end = 1'b1;
            if (data_f && (^{rx_sh_q, rx_par_q})) push = 1'b1;
            else rx_err_d = 1'b1;
          end
        end
        if (rx_end) state_d = (state_q == TX_WAIT || tx_accept) ? TX_INHIBIT : IDLE;
        else if (state_q == TX_WAIT || tx_accept) state_d = TX_WAIT;
        else if (bit_cnt_d < 4'd8) state_d = RX_DATA;
        else if (bit_cnt_d == 4'd8) state_d = RX_PARITY;
        else state_d = RX_STOP;
      end
      TX_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        if (inh_cnt_q == INH_W'(INH_CYC - 1)) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b1;
          bit_cnt_d  = '0;
          state_d    = TX_BITS;
        end
      end
      TX_BITS: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (dev_edge) begin
          data_low_d = ~tx_sh_q[0];
          tx_sh_d    = {1'b1, tx_sh_q[9:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) state_d = TX_ACK;
        end
      end
      TX_ACK: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (dev_edge) begin
          tx_done_d = ~data_f;
          tx_err_d  = data_f;
          state_d   = TX_RELEASE;
        end
      end
      TX_RELEASE: begin
        if (timeout) state_d = IDLE;
        else if (filt_q == 2'b11) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout && state_q inside {TX_BITS, TX_ACK, TX_RELEASE}) begin
      clk_low_d  = 1'b0;
      data_low_d = 1'b0;
      tx_err_d   = 1'b1;
    end
    if (state_d == TX_INHIBIT) clk_low_d = 1'b1;
  end

  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      tx_sh_q    <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      rx_error_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      tx_sh_q    <= tx_sh_d;
      inh_cnt_q  <= inh_cnt_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      rx_error_q <= rx_err_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      // The inhibit phase is host-timed, so the gap timer restarts when TX_BITS begins.
      if (state_q == IDLE || state_q == TX_INHIBIT || dev_edge) to_cnt_q <= '0;
      else if (!timeout) to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign clkps2  = clk_low_q  ? 1'b0 : 1'bz;
  assign dataps2 = data_low_q ? 1'b0 : 1'bz;

  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full, pop, do_push;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = rx_ready && !fifo_empty;
  assign do_push    = push && (!fifo_full || pop);

  always_ff @(posedge clk_chipset) begin
    if (do_push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      rx_overflow_q <= push && fifo_full && !pop;
    end
  end

  assign rx_valid    = !fifo_empty;
  assign rx_data     = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign rx_error    = rx_error_q;
  assign rx_overflow = rx_overflow_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;

endmodule
